// File: rtl/float_widen_convert.sv
// IEEE-754 widening converter (default binary32 -> binary64). Subnormal inputs are
// normalised one bit per cycle; NaNs keep their payload and signalling NaNs are quietened.
module float_widen_convert #(
    parameter int IN_EXP_W  = 8,
    parameter int IN_MAN_W  = 23,
    parameter int OUT_EXP_W = 11,
    parameter int OUT_MAN_W = 52
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_EXP_W+IN_MAN_W:0]      in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_EXP_W+OUT_MAN_W:0]    out_data,
    output logic                            nan_exception
);

    localparam int IN_BIAS  = (1 << (IN_EXP_W - 1)) - 1;
    localparam int OUT_BIAS = (1 << (OUT_EXP_W - 1)) - 1;
    localparam int PAD_W    = OUT_MAN_W - IN_MAN_W;
    localparam int K_W      = $clog2(IN_MAN_W + 1);
    localparam logic signed [OUT_EXP_W:0] NORM_ADJ = (OUT_EXP_W+1)'(OUT_BIAS - IN_BIAS);
    localparam logic signed [OUT_EXP_W:0] SUB_BASE = (OUT_EXP_W+1)'(OUT_BIAS - IN_BIAS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        NORM     = 2'd2,
        OUTPUT   = 2'd3
    } state_t;

    state_t                         state_r;
    logic [IN_EXP_W+IN_MAN_W:0]     data_r;
    logic [IN_MAN_W-1:0]            man_r;
    logic [K_W-1:0]                 k_r;

    logic                           sign_s;
    logic [IN_EXP_W-1:0]            exp_in_s;
    logic [IN_MAN_W-1:0]            frac_in_s;
    logic [IN_MAN_W-1:0]            man_shift_s;
    logic [K_W-1:0]                 k_next_s;
    logic signed [OUT_EXP_W:0]      exp_norm_s;
    logic signed [OUT_EXP_W:0]      exp_sub_s;
    logic [OUT_EXP_W-1:0]           class_exp_s;
    logic [OUT_MAN_W-1:0]           class_frac_s;
    logic                           class_snan_s;
    logic                           class_sub_s;

    // Left-align a narrow fraction in the wide fraction field.
    function automatic logic [OUT_MAN_W-1:0] pad_frac(input logic [IN_MAN_W-1:0] f);
        pad_frac = OUT_MAN_W'(f) << PAD_W;
    endfunction

    // Set the quiet bit while keeping the remaining payload bits.
    function automatic logic [IN_MAN_W-1:0] quiet_frac(input logic [IN_MAN_W-1:0] f);
        quiet_frac = {1'b1, f[IN_MAN_W-2:0]};
    endfunction

    // Field decode and exponent rebiasing for the captured operand.
    always_comb begin
        sign_s      = data_r[IN_EXP_W+IN_MAN_W];
        exp_in_s    = data_r[IN_MAN_W +: IN_EXP_W];
        frac_in_s   = data_r[IN_MAN_W-1:0];
        man_shift_s = {man_r[IN_MAN_W-2:0], 1'b0};
        k_next_s    = k_r + K_W'(1);
        exp_norm_s  = $signed({{(OUT_EXP_W+1-IN_EXP_W){1'b0}}, exp_in_s}) + NORM_ADJ;
        exp_sub_s   = SUB_BASE - $signed({{(OUT_EXP_W+1-K_W){1'b0}}, k_next_s});
    end

    // Classification of the captured operand into its output encoding.
    always_comb begin
        class_exp_s  = {OUT_EXP_W{1'b0}};
        class_frac_s = {OUT_MAN_W{1'b0}};
        class_snan_s = 1'b0;
        class_sub_s  = 1'b0;
        if (exp_in_s == {IN_EXP_W{1'b1}}) begin
            class_exp_s = {OUT_EXP_W{1'b1}};
            if (frac_in_s == {IN_MAN_W{1'b0}}) begin
                class_frac_s = {OUT_MAN_W{1'b0}};
            end else if (frac_in_s[IN_MAN_W-1]) begin
                class_frac_s = pad_frac(frac_in_s);
            end else begin
                class_frac_s = pad_frac(quiet_frac(frac_in_s));
                class_snan_s = 1'b1;
            end
        end else if (exp_in_s == {IN_EXP_W{1'b0}}) begin
            class_sub_s = (frac_in_s != {IN_MAN_W{1'b0}});
        end else begin
            class_exp_s  = OUT_EXP_W'(exp_norm_s);
            class_frac_s = pad_frac(frac_in_s);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= {(OUT_EXP_W+OUT_MAN_W+1){1'b0}};
            nan_exception <= 1'b0;
            data_r        <= {(IN_EXP_W+IN_MAN_W+1){1'b0}};
            man_r         <= {IN_MAN_W{1'b0}};
            k_r           <= {K_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_r   <= in_data;
                        in_ready <= 1'b0;
                        state_r  <= CLASSIFY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CLASSIFY: begin
                    if (class_sub_s) begin
                        man_r   <= frac_in_s;
                        k_r     <= {K_W{1'b0}};
                        state_r <= NORM;
                    end else begin
                        out_data      <= {sign_s, class_exp_s, class_frac_s};
                        nan_exception <= class_snan_s;
                        state_r       <= OUTPUT;
                    end
                end
                NORM: begin
                    man_r <= man_shift_s;
                    k_r   <= k_next_s;
                    // The bit about to shift out is the hidden one: normalisation is done.
                    if (man_r[IN_MAN_W-1]) begin
                        out_data      <= {sign_s, OUT_EXP_W'(exp_sub_s), pad_frac(man_shift_s)};
                        nan_exception <= 1'b0;
                        state_r       <= OUTPUT;
                    end else begin
                        state_r <= NORM;
                    end
                end
                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_widen_convert.sv
// Directed-vector bench for float_widen_convert (binary32 -> binary64).
module tb_float_widen_convert;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        nan_exception;

    int n_checks;
    int n_fail;

    float_widen_convert dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .nan_exception (nan_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for in_ready (bounded), present one operand and return just after the accept edge.
    task automatic send(input logic [31:0] v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises (gives 100 on timeout), capture the result, then pop it.
    task automatic run(input logic [31:0] v, output logic [63:0] d, output logic n, output int lat);
        send(v);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = out_data;
        n = nan_exception;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || nan_exception !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h nan=%b, want 0/0/0", out_valid, out_data, nan_exception);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_normal();
        logic [63:0] d;
        logic        n;
        int          lat;
        run(32'h3F800000, d, n, lat);
        n_checks++;
        if (d !== 64'h3FF0000000000000 || n !== 1'b0) begin
            n_fail++;
            $display("FAIL one: got %h nan=%b, want 3ff0000000000000 nan=0", d, n);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL one_latency: got %0d, want 2", lat);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL one_handshake: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
        run(32'hC0490FDB, d, n, lat);
        n_checks++;
        if (d !== 64'hC00921FB60000000 || n !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL neg_pi: got %h nan=%b lat=%0d, want c00921fb60000000 nan=0 lat=2", d, n, lat);
        end
    endtask

    task automatic test_subnormal();
        logic [63:0] d;
        logic        n;
        int          lat;
        run(32'h00000001, d, n, lat);
        n_checks++;
        if (d !== 64'h36A0000000000000 || n !== 1'b0 || lat !== 25) begin
            n_fail++;
            $display("FAIL min_sub: got %h nan=%b lat=%0d, want 36a0000000000000 nan=0 lat=25", d, n, lat);
        end
        run(32'h007FFFFF, d, n, lat);
        n_checks++;
        if (d !== 64'h380FFFFFC0000000 || lat !== 3) begin
            n_fail++;
            $display("FAIL max_sub: got %h lat=%0d, want 380fffffc0000000 lat=3", d, lat);
        end
        run(32'h80400000, d, n, lat);
        n_checks++;
        if (d !== 64'hB800000000000000 || lat !== 3) begin
            n_fail++;
            $display("FAIL neg_sub: got %h lat=%0d, want b800000000000000 lat=3", d, lat);
        end
    endtask

    task automatic test_nan();
        logic [63:0] d;
        logic        n;
        int          lat;
        run(32'h7FA00000, d, n, lat);
        n_checks++;
        if (d !== 64'h7FFC000000000000 || n !== 1'b1) begin
            n_fail++;
            $display("FAIL snan: got %h nan=%b, want 7ffc000000000000 nan=1", d, n);
        end
        run(32'hFFC00001, d, n, lat);
        n_checks++;
        if (d !== 64'hFFF8000020000000 || n !== 1'b0) begin
            n_fail++;
            $display("FAIL qnan: got %h nan=%b, want fff8000020000000 nan=0", d, n);
        end
    endtask

    logic [31:0] spec_in  [4] = '{32'h80000000, 32'h7F800000, 32'hFF800000, 32'h00000000};
    logic [63:0] spec_exp [4] = '{64'h8000000000000000, 64'h7FF0000000000000,
                                  64'hFFF0000000000000, 64'h0000000000000000};

    task automatic test_special();
        logic [63:0] d;
        logic        n;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run(spec_in[i], d, n, lat);
            n_checks++;
            if (d !== spec_exp[i] || n !== 1'b0 || lat !== 2) begin
                n_fail++;
                $display("FAIL special_%0d: in %h got %h nan=%b lat=%0d, want %h nan=0 lat=2",
                         i, spec_in[i], d, n, lat, spec_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        send(32'h3F800000);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = 32'h40000000;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 64'h3FF0000000000000 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles (last valid=%b data=%h ready=%b), want 0", bad, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_capture: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic        n;
        int          lat;
        send(32'h00000001);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_busy: got valid=%b ready=%b, want 0/0", out_valid, in_ready);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b data=%h, want 0/0", out_valid, out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(32'h40000000, d, n, lat);
        n_checks++;
        if (d !== 64'h4000000000000000 || lat !== 2) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat=%0d, want 4000000000000000 lat=2", d, lat);
        end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_result: got valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_normal();
        test_subnormal();
        test_nan();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
